// File: rtl/iob_target.sv
// iob_target: 68000-protocol responder on the IOB bus with eight R/W word registers,
// a read-only ID register and programmable wait states. Macro IOB_TARGET_VPA_EN adds 6800-style VPA cycles.
module iob_target #(
   parameter logic [7:0]  BASE_HI     = 8'hFC,
   parameter int unsigned WAIT_STATES = 2,
   parameter logic [15:0] ID_VALUE    = 16'h5E30
) (
   input  logic        CLK_IOB,
   input  logic        nRES,
   input  logic [23:1] A_IOB,
   input  logic        nAS_IOB,
   input  logic        nUDS_IOB,
   input  logic        nLDS_IOB,
   input  logic        nWE_IOB,
   input  logic [15:0] D_IOB_in,
   output logic [15:0] D_IOB_out,
   output logic        D_IOB_oe,
   output logic        nDTACK_IOB,
   output logic        nBERR_IOB,
   output logic        nVPA_IOB,
   input  logic        nVMA_IOB,
   input  logic        E_IOB
);

   localparam logic [3:0] WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      ACK,
      HOLD,
      BERR
`ifdef IOB_TARGET_VPA_EN
      ,
      VPA_VMA,
      VPA_EHI,
      VPA_ELO
`endif
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [3:0]  idx_q, idx_d;
   logic        rd_q, rd_d;
   logic        dtack_n_q, dtack_n_d;
   logic        berr_n_q, berr_n_d;
   logic [15:0] dout_q, dout_d;
   logic        oe_q, oe_d;
   logic [15:0] regs_q [8];
   logic [15:0] regs_d [8];
`ifdef IOB_TARGET_VPA_EN
   logic        vpa_n_q, vpa_n_d;
`endif

   logic        start;
   logic        bad_reg;
   logic        vpa_space;
   logic        vpa_illegal;
   logic [15:0] cur_val;
   logic [15:0] rd_val;
   logic [15:0] wr_val;
   logic        unused_ok;

   assign start     = !nAS_IOB && (!nUDS_IOB || !nLDS_IOB) && (A_IOB[23:16] == BASE_HI);
   assign bad_reg   = (A_IOB[4:1] > 4'd8) || ((A_IOB[4:1] == 4'd8) && !nWE_IOB);
   assign vpa_space = A_IOB[15];

`ifdef IOB_TARGET_VPA_EN
   assign vpa_illegal = 1'b0;
   assign unused_ok   = ^A_IOB[14:5];
`else
   // Without the VPA path the upper half of the window is simply unmapped.
   assign vpa_illegal = vpa_space;
   assign unused_ok   = ^{A_IOB[14:5], nVMA_IOB, E_IOB};
`endif

   assign cur_val = regs_q[idx_q[2:0]];
   assign rd_val  = idx_q[3] ? ID_VALUE : cur_val;
   assign wr_val  = {nUDS_IOB ? cur_val[15:8] : D_IOB_in[15:8],
                     nLDS_IOB ? cur_val[7:0]  : D_IOB_in[7:0]};

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      rd_d      = rd_q;
      dtack_n_d = dtack_n_q;
      berr_n_d  = berr_n_q;
      dout_d    = dout_q;
      oe_d      = oe_q;
      regs_d    = regs_q;
`ifdef IOB_TARGET_VPA_EN
      vpa_n_d   = vpa_n_q;
`endif

      case (state_q)
         IDLE: begin
            if (start) begin
               idx_d = A_IOB[4:1];
               rd_d  = nWE_IOB;
               if (bad_reg || vpa_illegal) begin
                  state_d = BERR;
`ifdef IOB_TARGET_VPA_EN
               end else if (vpa_space) begin
                  state_d = VPA_VMA;
                  vpa_n_d = 1'b0;
`endif
               end else if (WAIT_STATES == 0) begin
                  state_d = ACK;
               end else begin
                  state_d = WAIT;
                  cnt_d   = WAIT_LOAD;
               end
            end
         end

         WAIT: begin
            // Master timeout: drop the cycle without touching the register file.
            if (nAS_IOB) begin
               state_d = IDLE;
            end else if (cnt_q == 4'd0) begin
               state_d = ACK;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end

         ACK: begin
            dtack_n_d = 1'b0;
            if (rd_q) begin
               dout_d = rd_val;
               oe_d   = 1'b1;
            end else if (!idx_q[3]) begin
               regs_d[idx_q[2:0]] = wr_val;
            end
            state_d = HOLD;
         end

         HOLD, BERR: begin
            if (nAS_IOB) begin
               dtack_n_d = 1'b1;
               berr_n_d  = 1'b1;
               dout_d    = 16'h0000;
               oe_d      = 1'b0;
`ifdef IOB_TARGET_VPA_EN
               vpa_n_d   = 1'b1;
`endif
               state_d   = IDLE;
            end else if (state_q == BERR) begin
               berr_n_d = 1'b0;
            end
         end

`ifdef IOB_TARGET_VPA_EN
         VPA_VMA: begin
            if (nAS_IOB) begin
               vpa_n_d = 1'b1;
               state_d = IDLE;
            end else if (!nVMA_IOB) begin
               state_d = VPA_EHI;
            end
         end

         VPA_EHI: begin
            // The data phase happens on the edge that first sees E high.
            if (nAS_IOB) begin
               vpa_n_d = 1'b1;
               state_d = IDLE;
            end else if (E_IOB) begin
               if (rd_q) begin
                  dout_d = rd_val;
                  oe_d   = 1'b1;
               end else if (!idx_q[3]) begin
                  regs_d[idx_q[2:0]] = wr_val;
               end
               state_d = VPA_ELO;
            end
         end

         VPA_ELO: begin
            if (!E_IOB) begin
               state_d = HOLD;
            end
         end
`endif

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK_IOB or negedge nRES) begin
      if (!nRES) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         idx_q     <= 4'd0;
         rd_q      <= 1'b0;
         dtack_n_q <= 1'b1;
         berr_n_q  <= 1'b1;
         dout_q    <= 16'h0000;
         oe_q      <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            regs_q[i] <= 16'h0000;
         end
`ifdef IOB_TARGET_VPA_EN
         vpa_n_q   <= 1'b1;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         rd_q      <= rd_d;
         dtack_n_q <= dtack_n_d;
         berr_n_q  <= berr_n_d;
         dout_q    <= dout_d;
         oe_q      <= oe_d;
         regs_q    <= regs_d;
`ifdef IOB_TARGET_VPA_EN
         vpa_n_q   <= vpa_n_d;
`endif
      end
   end

   assign D_IOB_out  = dout_q;
   assign D_IOB_oe   = oe_q;
   assign nDTACK_IOB = dtack_n_q;
   assign nBERR_IOB  = berr_n_q;
`ifdef IOB_TARGET_VPA_EN
   assign nVPA_IOB   = vpa_n_q;
`else
   assign nVPA_IOB   = 1'b1;
`endif

endmodule
